// File: rtl/wash_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// wash_cycle_sequencer
//   Programme controller for the washing machine. A coin accepted in IDLE
//   starts the fill -> wash -> rinse -> spin sequence (wash+rinse repeated
//   once when double_wash was set at coin time). Each phase loads and starts
//   the shared countdown timer and advances when the timer reports done.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   coin_in      level; a high sample in IDLE starts a programme
//   double_wash  latched at coin acceptance; repeats wash+rinse once
//   timer_pause  level; honoured in SPIN only
//   tmr_done     timer completion flag (level)
//   door_open    only with DOOR_INTERLOCK_EN: pauses any active phase and
//                blocks coin acceptance in IDLE
//   tmr_value    duration loaded into the timer, held until next phase entry
//   tmr_start    one-cycle pulse on phase entry
//   tmr_hold     freezes the timer countdown
//   phase        0 IDLE, 1 FILL, 2 WASH, 3 RINSE, 4 SPIN, 5 DONE
//   door_lock    high in FILL..SPIN
//   prog_done    one-cycle pulse in DONE
//
// Optional feature macro: DOOR_INTERLOCK_EN
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a coin
// S_FILL  | filling drum, timer loaded with FILL_T
// S_WASH  | washing, timer loaded with WASH_T
// S_RINSE | rinsing, timer loaded with RINSE_T; may loop back to WASH
// S_SPIN  | spinning, timer loaded with SPIN_T; pausable
// S_DONE  | one-cycle completion state, pulses prog_done
// -----------------------------------------------------------------------------
module wash_cycle_sequencer #(
    parameter int unsigned FILL_T  = 2,
    parameter int unsigned WASH_T  = 5,
    parameter int unsigned RINSE_T = 2,
    parameter int unsigned SPIN_T  = 1,
    parameter int          VALUE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_in,
    input  logic               double_wash,
    input  logic               timer_pause,
    input  logic               tmr_done,
`ifdef DOOR_INTERLOCK_EN
    input  logic               door_open,
`endif
    output logic [VALUE_W-1:0] tmr_value,
    output logic               tmr_start,
    output logic               tmr_hold,
    output logic [2:0]         phase,
    output logic               door_lock,
    output logic               prog_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               dw_q, dw_d;
    logic               second_q, second_d;
    logic [1:0]         guard_q, guard_d;
    logic [VALUE_W-1:0] tmr_value_q, tmr_value_d;
    logic               tmr_start_q, tmr_start_d;
    logic               tmr_hold_q, tmr_hold_d;
    logic               door_lock_q, door_lock_d;
    logic               prog_done_q, prog_done_d;

    logic               active;
    logic               pause_req;
    logic               coin_ok;
    logic               advance;
    logic               entry;

    function automatic logic [VALUE_W-1:0] phase_dur(input state_t s);
        logic [VALUE_W-1:0] d;
        d = '0;
        case (s)
            S_FILL:  d = VALUE_W'(FILL_T);
            S_WASH:  d = VALUE_W'(WASH_T);
            S_RINSE: d = VALUE_W'(RINSE_T);
            S_SPIN:  d = VALUE_W'(SPIN_T);
            default: d = '0;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d     = state_q;
        dw_d        = dw_q;
        second_d    = second_q;
        guard_d     = guard_q;
        tmr_value_d = tmr_value_q;
        tmr_start_d = 1'b0;
        tmr_hold_d  = 1'b0;

        active = (state_q == S_FILL) || (state_q == S_WASH) ||
                 (state_q == S_RINSE) || (state_q == S_SPIN);

`ifdef DOOR_INTERLOCK_EN
        pause_req = ((state_q == S_SPIN) && timer_pause) || (active && door_open);
        coin_ok   = coin_in && !door_open;
`else
        pause_req = (state_q == S_SPIN) && timer_pause;
        coin_ok   = coin_in;
`endif

        // A done sample only counts once the guard has matured and the
        // timer was not already frozen; a pause rising in the same cycle
        // as done therefore loses.
        advance = (guard_q == 2'd2) && !tmr_hold_q && tmr_done;

        if (active && !tmr_hold_q && (guard_q != 2'd2)) begin
            guard_d = guard_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (coin_ok) begin
                    state_d  = S_FILL;
                    dw_d     = double_wash;
                    second_d = 1'b0;
                end
            end
            S_FILL:  if (advance) state_d = S_WASH;
            S_WASH:  if (advance) state_d = S_RINSE;
            S_RINSE: begin
                if (advance) begin
                    if (dw_q && !second_q) begin
                        state_d  = S_WASH;
                        second_d = 1'b1;
                    end else begin
                        state_d = S_SPIN;
                    end
                end
            end
            S_SPIN:  if (advance) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        entry = (state_d != state_q) &&
                ((state_d == S_FILL) || (state_d == S_WASH) ||
                 (state_d == S_RINSE) || (state_d == S_SPIN));

        if (entry) begin
            tmr_start_d = 1'b1;
            tmr_value_d = phase_dur(state_d);
            guard_d     = 2'd0;
        end

        // Hold only follows the pause request while staying in the phase;
        // any transition drops it.
        if (active && (state_d == state_q)) begin
            tmr_hold_d = pause_req;
        end

        door_lock_d = (state_d == S_FILL) || (state_d == S_WASH) ||
                      (state_d == S_RINSE) || (state_d == S_SPIN);
        prog_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dw_q        <= 1'b0;
            second_q    <= 1'b0;
            guard_q     <= 2'd0;
            tmr_value_q <= '0;
            tmr_start_q <= 1'b0;
            tmr_hold_q  <= 1'b0;
            door_lock_q <= 1'b0;
            prog_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dw_q        <= dw_d;
            second_q    <= second_d;
            guard_q     <= guard_d;
            tmr_value_q <= tmr_value_d;
            tmr_start_q <= tmr_start_d;
            tmr_hold_q  <= tmr_hold_d;
            door_lock_q <= door_lock_d;
            prog_done_q <= prog_done_d;
        end
    end

    assign tmr_value = tmr_value_q;
    assign tmr_start = tmr_start_q;
    assign tmr_hold  = tmr_hold_q;
    assign phase     = state_q;
    assign door_lock = door_lock_q;
    assign prog_done = prog_done_q;

endmodule
